// File: rtl/ioq_arb.sv
// ioq_arb: round-robin arbiter onto the I/O-queue request port with tag pool.
// Define IOQ_ARB_WDOG_EN to build the outstanding-request watchdog.
module ioq_arb #(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                   user_clk,
  input  logic                   user_reset_n,
  input  logic                   user_lnk_up,
  input  logic [NUM_REQ*256-1:0] req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [255:0]           arb_ioq_data,
  output logic                   arb_ioq_valid,
  input  logic                   arb_ioq_ready,
  input  logic [255:0]           ioq_arb_data,
  input  logic                   ioq_arb_valid,
  output logic [255:0]           rsp_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [6:0]             outstanding,
  output logic                   err_unexp_tag,
  output logic                   err_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] TYPE_MEMWR = 4'd1;

  logic [63:0]        alloc_q, alloc_d;
  logic [IW-1:0]      owner_q [64];
  logic [IW-1:0]      rr_q, rr_d;
  logic [6:0]         out_q, out_d;
  logic [255:0]       arb_data_q;
  logic               arb_valid_q;
  logic [255:0]       rsp_data_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               err_unexp_q;

  logic [5:0]         free_tag;
  logic               any_free;
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      win;
  logic [IW-1:0]      idx;
  logic               found;
  logic               accept;
  logic               win_np;
  logic [255:0]       win_word;
  logic [255:0]       out_word;
  logic [5:0]         cpl_tag;
  logic               cpl_hit;

  // Descending scan so the lowest free tag is the last one assigned.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int t = 63; t >= 1; t--) begin
      if (!alloc_q[t]) begin
        free_tag = 6'(t);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & user_lnk_up &
        ((req_data[256*i +: 4] == TYPE_MEMWR) | any_free);
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept = found & user_reset_n &
    (~arb_valid_q | arb_ioq_ready);
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

  assign win_word = req_data[256*int'(win) +: 256];
  assign win_np   = win_word[3:0] != TYPE_MEMWR;
  assign out_word = {win_word[255:221],
                     win_np ? free_tag : 6'd0,
                     win_word[214:0]};

  assign cpl_tag = ioq_arb_data[220:215];
  assign cpl_hit = ioq_arb_valid & alloc_q[cpl_tag];

  always_comb begin
    alloc_d = alloc_q;
    if (cpl_hit)
      alloc_d[cpl_tag] = 1'b0;
    if (accept && win_np)
      alloc_d[free_tag] = 1'b1;
    alloc_d[0] = 1'b0;
    out_d = out_q + 7'(accept & win_np) - 7'(cpl_hit);
    rr_d = rr_q;
    if (accept)
      rr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      alloc_q     <= '0;
      rr_q        <= '0;
      out_q       <= '0;
      arb_data_q  <= '0;
      arb_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      err_unexp_q <= 1'b0;
      for (int t = 0; t < 64; t++)
        owner_q[t] <= '0;
    end else begin
      alloc_q <= alloc_d;
      rr_q    <= rr_d;
      out_q   <= out_d;
      if (accept) begin
        arb_data_q  <= out_word;
        arb_valid_q <= 1'b1;
      end else if (arb_ioq_ready) begin
        arb_valid_q <= 1'b0;
      end
      if (accept && win_np)
        owner_q[free_tag] <= win;
      rsp_valid_q <= cpl_hit ?
        (NUM_REQ'(1) << owner_q[cpl_tag]) : '0;
      if (cpl_hit)
        rsp_data_q <= ioq_arb_data;
      err_unexp_q <= ioq_arb_valid & ~cpl_hit;
    end
  end

`ifdef IOQ_ARB_WDOG_EN
  logic [15:0] wdog_q;
  logic        tmo_q;

  // Counts cycles with tags in flight; any completion proves progress.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else if (out_d == 7'd0 || cpl_hit) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else if (wdog_q + 16'd1 == TIMEOUT) begin
      wdog_q <= '0;
      tmo_q  <= 1'b1;
    end else begin
      wdog_q <= wdog_q + 16'd1;
      tmo_q  <= 1'b0;
    end
  end

  assign err_timeout = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_timeout    = 1'b0;
`endif

  assign arb_ioq_data  = arb_data_q;
  assign arb_ioq_valid = arb_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign outstanding   = out_q;
  assign err_unexp_tag = err_unexp_q;

endmodule

// File: tb/tb_ioq_arb.sv
// tb_ioq_arb: scoreboard bench for ioq_arb, directed vectors.
// Watchdog expectations follow IOQ_ARB_WDOG_EN.
module tb_ioq_arb;

  localparam int N = 4;
  localparam logic [3:0] MEMRD  = 4'd0;
  localparam logic [3:0] MEMWR  = 4'd1;
  localparam logic [3:0] CFGRD0 = 4'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lnk = 1'b0;
  logic [N*256-1:0] req_data = '0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [255:0]     arb_ioq_data;
  logic             arb_ioq_valid;
  logic             arb_ioq_ready = 1'b0;
  logic [255:0]     ioq_arb_data = '0;
  logic             ioq_arb_valid = 1'b0;
  logic [255:0]     rsp_data;
  logic [N-1:0]     rsp_valid;
  logic [6:0]       outstanding;
  logic             err_unexp_tag;
  logic             err_timeout;

  always #5 clk = ~clk;

  ioq_arb #(.NUM_REQ(N), .TIMEOUT(16'd100)) dut (
    .user_clk     (clk),
    .user_reset_n (rst_n),
    .user_lnk_up  (lnk),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .arb_ioq_data (arb_ioq_data),
    .arb_ioq_valid(arb_ioq_valid),
    .arb_ioq_ready(arb_ioq_ready),
    .ioq_arb_data (ioq_arb_data),
    .ioq_arb_valid(ioq_arb_valid),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid),
    .outstanding  (outstanding),
    .err_unexp_tag(err_unexp_tag),
    .err_timeout  (err_timeout)
  );

  typedef struct packed {
    logic [N-1:0] sel;
    logic         err;
    logic [255:0] data;
  } rsp_t;

  logic [255:0] exp_req_q [$];
  rsp_t         exp_rsp_q [$];
  int cmp = 0;
  int bad = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] req);
    cmp++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] mk(logic [3:0] ty, logic [31:0] a,
                                      logic [5:0] tag);
    logic [255:0] w;
    w = '0;
    w[3:0]     = ty;
    w[67:4]    = {32'hA0A0_0000, a};
    w[195:68]  = {4{a ^ 32'h5A5A_1234}};
    w[203:196] = 8'hF1;
    w[214:204] = 11'd1;
    w[220:215] = tag;
    w[255:221] = 35'h4_0000_0ABC;
    return w;
  endfunction

  task automatic set_req(int i, logic [255:0] w);
    req_data[256*i +: 256] = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    rsp_t e;
    if (!rst_n) return;
    if (arb_ioq_valid && arb_ioq_ready) begin
      if (exp_req_q.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL req_extra: got %0h want none", arb_ioq_data);
      end else begin
        chk("req_word", arb_ioq_data, exp_req_q.pop_front());
      end
    end
    if (rsp_valid != '0 || err_unexp_tag) begin
      if (exp_rsp_q.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL rsp_extra: got sel %b err %b want none",
                 rsp_valid, err_unexp_tag);
      end else begin
        e = exp_rsp_q.pop_front();
        chk("rsp_sel", rsp_valid, e.sel);
        chk("rsp_err", err_unexp_tag, e.err);
        if (!e.err) chk("rsp_data", rsp_data, e.data);
      end
    end
  endtask

  task automatic reset_dut();
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    ioq_arb_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_accepts(int n, string name);
    int got;
    int t;
    got = 0;
    t = 0;
    while (got < n && t < n + 50) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) got++;
      t++;
      tick();
    end
    chk(name, got, n);
  endtask

  task automatic cpl(logic [255:0] w, logic [N-1:0] sel, logic err);
    ioq_arb_data = w;
    ioq_arb_valid = 1'b1;
    exp_rsp_q.push_back({sel, err, w});
    tick();
    ioq_arb_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] wa;
    int first;
    int second;
    int pulses;

    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none

    // Reset values, with requests pending to prove req_ready is gated.
    lnk = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arb_valid", arb_ioq_valid, 0);
    chk("rst_arb_data", arb_ioq_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_unexp", err_unexp_tag, 0);
    chk("rst_err_tmo", err_timeout, 0);
    chk("rst_req_ready", req_ready, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    arb_ioq_ready = 1'b1;

    // Single non-posted request
    set_req(0, mk(CFGRD0, 32'h1000, 6'h3F));
    exp_req_q.push_back(mk(CFGRD0, 32'h1000, 6'd1));
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_outst1", outstanding, 1);
    tick();
    cpl(mk(CFGRD0, 32'hC001, 6'd1), 4'b0001, 1'b0);
    @(negedge clk);
    chk("t1_outst0", outstanding, 0);

    // Round-robin rotation
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, mk(MEMRD, 32'h200 + i, 6'd0));
    exp_req_q.push_back(mk(MEMRD, 32'h200, 6'd1));
    exp_req_q.push_back(mk(MEMRD, 32'h201, 6'd2));
    exp_req_q.push_back(mk(MEMRD, 32'h202, 6'd3));
    exp_req_q.push_back(mk(MEMRD, 32'h203, 6'd4));
    exp_req_q.push_back(mk(MEMRD, 32'h200, 6'd5));
    req_valid = 4'hF;
    wait_accepts(5, "rr_cnt");
    req_valid = '0;
    @(negedge clk);
    chk("rr_outst", outstanding, 5);

    // Backpressure
    reset_dut();
    wa = mk(MEMRD, 32'h300, 6'd1);
    set_req(1, mk(MEMRD, 32'h300, 6'd0));
    set_req(2, mk(MEMRD, 32'h301, 6'd0));
    exp_req_q.push_back(wa);
    exp_req_q.push_back(mk(MEMRD, 32'h301, 6'd2));
    arb_ioq_ready = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("bp_first", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", arb_ioq_valid, 1);
      chk("bp_data", arb_ioq_data, wa);
      tick();
    end
    arb_ioq_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("bp_outst", outstanding, 2);

    // Tag exhaustion
    reset_dut();
    set_req(0, mk(MEMRD, 32'h400, 6'd0));
    for (int t = 1; t <= 63; t++)
      exp_req_q.push_back(mk(MEMRD, 32'h400, 6'(t)));
    req_valid = 4'b0001;
    wait_accepts(63, "fill_cnt");
    req_valid = '0;
    @(negedge clk);
    chk("full_outst", outstanding, 63);
    tick();
    set_req(1, mk(MEMRD, 32'h401, 6'd0));
    set_req(2, mk(MEMWR, 32'h402, 6'd5));
    exp_req_q.push_back(mk(MEMWR, 32'h402, 6'd0));
    req_valid = 4'b0110;
    @(negedge clk);
    chk("full_posted", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("full_stall", req_ready, 0);
    tick();
    ioq_arb_data = mk(MEMRD, 32'hC017, 6'd17);
    ioq_arb_valid = 1'b1;
    exp_rsp_q.push_back({4'b0001, 1'b0, ioq_arb_data});
    exp_req_q.push_back(mk(MEMRD, 32'h401, 6'd17));
    @(negedge clk);
    chk("reuse_early", req_ready, 0);
    tick();
    ioq_arb_valid = 1'b0;
    @(negedge clk);
    chk("reuse_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("reuse_outst", outstanding, 63);

    // Unexpected tag, then a tag orphaned by reset
    reset_dut();
    cpl(mk(MEMRD, 32'hC009, 6'd9), 4'b0000, 1'b1);
    @(negedge clk);
    chk("unexp_outst", outstanding, 0);
    tick();
    set_req(3, mk(CFGRD0, 32'h500, 6'd0));
    exp_req_q.push_back(mk(CFGRD0, 32'h500, 6'd1));
    req_valid = 4'b1000;
    @(negedge clk);
    chk("orph_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("orph_outst1", outstanding, 1);
    reset_dut();
    @(negedge clk);
    chk("orph_outst0", outstanding, 0);
    tick();
    cpl(mk(CFGRD0, 32'hC001, 6'd1), 4'b0000, 1'b1);
    @(negedge clk);

    // Watchdog: one request never completed
    reset_dut();
    set_req(0, mk(MEMRD, 32'h600, 6'd0));
    exp_req_q.push_back(mk(MEMRD, 32'h600, 6'd1));
    req_valid = 4'b0001;
    @(negedge clk);
    chk("wd_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    first = 0;
    second = 0;
    pulses = 0;
    for (int c = 1; c <= 230; c++) begin
      @(negedge clk);
      if (err_timeout) begin
        pulses++;
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      tick();
    end
`ifdef IOQ_ARB_WDOG_EN
    chk("wd_first", first, 100);
    chk("wd_second", second, 200);
    chk("wd_pulses", pulses, 2);
`else
    chk("wd_first", first, 0);
    chk("wd_pulses", pulses, 0);
`endif
    chk("wd_outst", outstanding, 1);

    repeat (2) @(posedge clk);
    chk("req_q_empty", exp_req_q.size(), 0);
    chk("rsp_q_empty", exp_rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
